regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
Write-back scheduler and scoreboard for the 64 x 32-bit register file.
- Shares the file's single write port (we/wa/wd) between two write-back requesters, using round-robin arbitration and valid/ready handshakes.
- Keeps a per-register busy scoreboard. Issue logic reserves destinations and queries source hazards against it.
- Sits between the execute/memory write-back paths and the regfile write port.

Parameters:
ADDR_W, 6, register address width
DATA_W, 32, register data width
NREGS, 64, number of registers (2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rsv_valid  in  1  issue requests reservation of rsv_addr
rsv_addr  in  ADDR_W  destination register to reserve
rsv_ready  out  1  reservation accepted this cycle
q_ra1  in  ADDR_W  source address 1 to check
q_ra2  in  ADDR_W  source address 2 to check
haz1  out  1  q_ra1 has a pending write
haz2  out  1  q_ra2 has a pending write
wb0_valid  in  1  requester 0 (ALU) write-back valid
wb0_addr  in  ADDR_W  requester 0 destination
wb0_data  in  DATA_W  requester 0 data
wb0_ready  out  1  requester 0 granted
wb1_valid  in  1  requester 1 (load) write-back valid
wb1_addr  in  ADDR_W  requester 1 destination
wb1_data  in  DATA_W  requester 1 data
wb1_ready  out  1  requester 1 granted
rf_we  out  1  regfile write enable
rf_wa  out  ADDR_W  regfile write address
rf_wd  out  DATA_W  regfile write data
busy_cnt  out  ADDR_W+1  number of busy registers
wb_err  out  1  sticky: write-back to a non-busy register

Behaviour:
Reset (asynchronous, reset=1):
- busy[] = 0, busy_cnt = 0.
- last_grant = 1, so requester 0 wins first.
- rf_we = 0, rf_wa = 0, rf_wd = 0, wb_err = 0.
- Outputs are held while reset is high.
- Reset mid-operation drops any in-flight write: the registered rf_we is cleared immediately.

Arbitration (combinational grant, registered write port):
- Only wb0_valid: wb0_ready = 1.
- Only wb1_valid: wb1_ready = 1.
- Both valid: grant the requester not equal to last_grant; the other sees ready = 0.
- A handshake is valid & ready. On a handshake, last_grant takes the granted index.
- At most one handshake per cycle.
- A requester holds valid/addr/data stable until ready. Ready never depends on the ungranted side's data.
- Write latency is 1 cycle: in the cycle after a handshake, rf_we = 1 with the captured addr/data.
- No handshake in a cycle: rf_we = 0 the next cycle. rf_wa and rf_wd hold their last value.

Register 0:
- Never reserved: rsv_addr = 0 gives rsv_ready = 1 with no state change.
- A write-back to 0 completes its handshake but produces rf_we = 0 and no scoreboard change.
- wb_err is not set for register 0.

Scoreboard:
- rsv_ready = rsv_valid & ~busy[rsv_addr]. This uses registered busy only and stalls WAW on a busy register.
- An accepted reservation sets busy[rsv_addr] at the next edge.
- A write-back handshake to address a != 0 clears busy[a] at the next edge.
- If that register was not busy, the data is still written and wb_err sets; it stays set until reset.
- Same-edge reservation and clear cannot target the same register, because rsv_ready requires ~busy. Set and clear on different registers both take effect.
- haz1 = busy[q_ra1], haz2 = busy[q_ra2] from registered state; q_ra = 0 gives 0.
- There is no bypass of the same-cycle handshake.
- busy_cnt tracks the popcount of busy[] incrementally: +1 on set, -1 on clear, net 0 when both occur.

Width rules:
- Addresses are used unmodified; indices >= NREGS cannot occur when NREGS = 2**ADDR_W.
- busy_cnt saturates at NREGS (reachable max 63).

Test Plan:
1. Reset, then reserve r5 (rsv_addr=5); next cycle q_ra1=5 -> haz1=1, busy_cnt=1. Re-reserve r5 -> rsv_ready=0.
2. With r5 busy, wb0 valid addr=5 data=0xDEADBEEF -> wb0_ready=1 the same cycle. Next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. Following cycle haz1=0, busy_cnt=0, wb_err=0.
3. Reserve r3 and r4, then wb0 (addr 3) and wb1 (addr 4) valid together for two cycles -> cycle 1 grants wb0 (after reset), cycle 2 grants wb1. rf writes appear at r3 then r4 on consecutive cycles; busy_cnt goes 2 -> 1 -> 0.
4. wb1 valid addr=0 data=0x1234 -> wb1_ready=1, next cycle rf_we=0, busy_cnt unchanged, wb_err=0. rsv_addr=0 -> rsv_ready=1, haz for q_ra1=0 stays 0.
5. wb0 to non-busy r9 data=0x55 -> rf_we=1, rf_wa=9, rf_wd=0x55 next cycle; wb_err=1 and stays 1 until reset.
6. Reserve r7; assert reset asynchronously (no clock edge) while a write-back is granted -> rf_we, busy_cnt, haz1 (q_ra1=7) and wb_err all 0 immediately. After release, wb0 and wb1 both valid -> wb0 granted first.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus: reservation/hazard query, two write-back requesters,
// regfile write port and status.
interface regfile_wb_sched_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ready;
    logic [ADDR_W-1:0] q_ra1;
    logic [ADDR_W-1:0] q_ra2;
    logic              haz1;
    logic              haz2;
    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_addr;
    logic [DATA_W-1:0] wb0_data;
    logic              wb0_ready;
    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_addr;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W:0]   busy_cnt;
    logic              wb_err;

    modport master (
        output rsv_valid, rsv_addr, q_ra1, q_ra2,
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        input  rsv_ready, haz1, haz2, wb0_ready, wb1_ready,
        input  rf_we, rf_wa, rf_wd, busy_cnt, wb_err
    );

    modport slave (
        input  rsv_valid, rsv_addr, q_ra1, q_ra2,
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        output rsv_ready, haz1, haz2, wb0_ready, wb1_ready,
        output rf_we, rf_wa, rf_wd, busy_cnt, wb_err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back arbiter for the single regfile write port, plus a
// per-register busy scoreboard used by issue for reservations and hazard checks.
module regfile_wb_sched #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int NREGS  = 64
) (
    input logic               clk,
    input logic               reset,
    regfile_wb_sched_if.slave bus
);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(NREGS);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [NREGS-1:0]  busy_r;
    logic [ADDR_W:0]   busy_cnt_r;
    logic              last_grant_r;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_wa_r;
    logic [DATA_W-1:0] rf_wd_r;
    logic              wb_err_r;

    logic              gnt0_s;
    logic              gnt1_s;
    logic              hs_s;
    logic [ADDR_W-1:0] hs_addr_s;
    logic [DATA_W-1:0] hs_data_s;
    logic              rsv_ready_s;
    logic              set_s;
    logic              clr_s;
    logic              clr_busy_s;
    logic              err_s;
    logic [NREGS-1:0]  busy_nxt_s;
    logic [ADDR_W:0]   busy_cnt_nxt_s;

    // Grant selection: a lone requester always wins; on contention the one not granted last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case ({bus.wb1_valid, bus.wb0_valid})
            2'b01: gnt0_s = 1'b1;
            2'b10: gnt1_s = 1'b1;
            2'b11: begin
                if (last_grant_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    // Mux the granted requester onto the handshake path.
    always_comb begin
        hs_s = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            hs_addr_s = bus.wb1_addr;
            hs_data_s = bus.wb1_data;
        end else begin
            hs_addr_s = bus.wb0_addr;
            hs_data_s = bus.wb0_data;
        end
    end

    // Scoreboard update terms; register 0 is never tracked (busy_r[0] stays 0).
    always_comb begin
        rsv_ready_s = bus.rsv_valid & ~busy_r[bus.rsv_addr];
        set_s       = rsv_ready_s & (bus.rsv_addr != ADDR_ZERO);
        clr_s       = hs_s & (hs_addr_s != ADDR_ZERO);
        clr_busy_s  = clr_s & busy_r[hs_addr_s];
        err_s       = clr_s & ~busy_r[hs_addr_s];
    end

    // Next busy vector; set applied after clear so a reservation is never lost.
    always_comb begin
        busy_nxt_s = busy_r;
        if (clr_s) begin
            busy_nxt_s[hs_addr_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_s) begin
            busy_nxt_s[bus.rsv_addr] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
    end

    // Incremental popcount: only a clear of a genuinely busy entry decrements.
    always_comb begin
        busy_cnt_nxt_s = busy_cnt_r;
        case ({set_s, clr_busy_s})
            2'b10: begin
                if (busy_cnt_r != CNT_MAX) begin
                    busy_cnt_nxt_s = busy_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    busy_cnt_nxt_s = busy_cnt_r;
                end
            end
            2'b01: busy_cnt_nxt_s = busy_cnt_r - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_cnt_nxt_s = busy_cnt_r;
        endcase
    end

    // Scoreboard state and busy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= {NREGS{1'b0}};
            busy_cnt_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Round-robin pointer; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (hs_s) begin
            last_grant_r <= gnt1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Registered write port: one cycle after a handshake; address/data hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r <= 1'b0;
            rf_wa_r <= {ADDR_W{1'b0}};
            rf_wd_r <= {DATA_W{1'b0}};
        end else if (clr_s) begin
            rf_we_r <= 1'b1;
            rf_wa_r <= hs_addr_s;
            rf_wd_r <= hs_data_s;
        end else begin
            rf_we_r <= 1'b0;
            rf_wa_r <= rf_wa_r;
            rf_wd_r <= rf_wd_r;
        end
    end

    // Sticky flag for a write-back that found its destination not reserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_err_r <= 1'b0;
        end else if (err_s) begin
            wb_err_r <= 1'b1;
        end else begin
            wb_err_r <= wb_err_r;
        end
    end

    assign bus.rsv_ready = rsv_ready_s;
    assign bus.haz1      = busy_r[bus.q_ra1];
    assign bus.haz2      = busy_r[bus.q_ra2];
    assign bus.wb0_ready = gnt0_s;
    assign bus.wb1_ready = gnt1_s;
    assign bus.rf_we     = rf_we_r;
    assign bus.rf_wa     = rf_wa_r;
    assign bus.rf_wd     = rf_wd_r;
    assign bus.busy_cnt  = busy_cnt_r;
    assign bus.wb_err    = wb_err_r;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reservations, arbitration, register 0,
// error flag and asynchronous reset.
module tb_regfile_wb_sched;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_wb_sched_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    regfile_wb_sched #(.ADDR_W(6), .DATA_W(32), .NREGS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = 6'd0;
        bus.q_ra1     = 6'd0;
        bus.q_ra2     = 6'd0;
        bus.wb0_valid = 1'b0;
        bus.wb0_addr  = 6'd0;
        bus.wb0_data  = 32'd0;
        bus.wb1_valid = 1'b0;
        bus.wb1_addr  = 6'd0;
        bus.wb1_data  = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    task automatic reserve(input logic [5:0] a);
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = a;
        step();
        bus.rsv_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk("reset_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("reset_rf_wa", {26'd0, bus.rf_wa}, 32'd0);
        chk("reset_rf_wd", bus.rf_wd, 32'd0);
        chk("reset_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
        chk("reset_wb_err", {31'd0, bus.wb_err}, 32'd0);
        #2;
        reset = 1'b0;
        step();
    endtask

    task automatic test_reserve();
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 6'd5;
        #1;
        chk("rsv_ready_r5_first", {31'd0, bus.rsv_ready}, 32'd1);
        step();
        bus.q_ra1 = 6'd5;
        bus.q_ra2 = 6'd6;
        #1;
        chk("haz1_r5", {31'd0, bus.haz1}, 32'd1);
        chk("haz2_r6", {31'd0, bus.haz2}, 32'd0);
        chk("busy_cnt_one", {25'd0, bus.busy_cnt}, 32'd1);
        chk("rsv_ready_r5_waw", {31'd0, bus.rsv_ready}, 32'd0);
        step();
        bus.rsv_valid = 1'b0;
        chk("busy_cnt_no_double", {25'd0, bus.busy_cnt}, 32'd1);
    endtask

    task automatic test_writeback();
        bus.wb0_valid = 1'b1;
        bus.wb0_addr  = 6'd5;
        bus.wb0_data  = 32'hDEADBEEF;
        #1;
        chk("wb0_ready_solo", {31'd0, bus.wb0_ready}, 32'd1);
        chk("haz1_before_edge", {31'd0, bus.haz1}, 32'd1);
        step();
        bus.wb0_valid = 1'b0;
        chk("wb_rf_we", {31'd0, bus.rf_we}, 32'd1);
        chk("wb_rf_wa", {26'd0, bus.rf_wa}, 32'd5);
        chk("wb_rf_wd", bus.rf_wd, 32'hDEADBEEF);
        step();
        chk("wb_rf_we_drop", {31'd0, bus.rf_we}, 32'd0);
        chk("wb_rf_wa_hold", {26'd0, bus.rf_wa}, 32'd5);
        chk("wb_rf_wd_hold", bus.rf_wd, 32'hDEADBEEF);
        chk("wb_haz1_clear", {31'd0, bus.haz1}, 32'd0);
        chk("wb_busy_cnt_zero", {25'd0, bus.busy_cnt}, 32'd0);
        chk("wb_no_err", {31'd0, bus.wb_err}, 32'd0);
    endtask

    task automatic test_arbitration();
        do_reset();
        step();
        reserve(6'd3);
        reserve(6'd4);
        reserve(6'd6);
        chk("arb_busy_cnt_3", {25'd0, bus.busy_cnt}, 32'd3);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 6'd3; bus.wb0_data = 32'hA0A0_0003;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 6'd4; bus.wb1_data = 32'hB0B0_0004;
        #1;
        chk("arb_c1_wb0_ready", {31'd0, bus.wb0_ready}, 32'd1);
        chk("arb_c1_wb1_ready", {31'd0, bus.wb1_ready}, 32'd0);
        step();
        bus.wb0_addr = 6'd6; bus.wb0_data = 32'hA0A0_0006;
        #1;
        chk("arb_c2_wb0_ready", {31'd0, bus.wb0_ready}, 32'd0);
        chk("arb_c2_wb1_ready", {31'd0, bus.wb1_ready}, 32'd1);
        chk("arb_c2_rf_wa", {26'd0, bus.rf_wa}, 32'd3);
        chk("arb_c2_rf_wd", bus.rf_wd, 32'hA0A0_0003);
        chk("arb_c2_busy_cnt", {25'd0, bus.busy_cnt}, 32'd2);
        step();
        bus.wb1_valid = 1'b0;
        #1;
        chk("arb_c3_wb0_ready", {31'd0, bus.wb0_ready}, 32'd1);
        chk("arb_c3_rf_we", {31'd0, bus.rf_we}, 32'd1);
        chk("arb_c3_rf_wa", {26'd0, bus.rf_wa}, 32'd4);
        chk("arb_c3_rf_wd", bus.rf_wd, 32'hB0B0_0004);
        chk("arb_c3_busy_cnt", {25'd0, bus.busy_cnt}, 32'd1);
        step();
        bus.wb0_valid = 1'b0;
        chk("arb_c4_rf_wa", {26'd0, bus.rf_wa}, 32'd6);
        chk("arb_c4_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
        chk("arb_no_err", {31'd0, bus.wb_err}, 32'd0);
    endtask

    task automatic test_reg0();
        bus.wb1_valid = 1'b1; bus.wb1_addr = 6'd0; bus.wb1_data = 32'h1234;
        #1;
        chk("r0_wb1_ready", {31'd0, bus.wb1_ready}, 32'd1);
        step();
        bus.wb1_valid = 1'b0;
        chk("r0_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("r0_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
        chk("r0_wb_err", {31'd0, bus.wb_err}, 32'd0);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 6'd0; bus.q_ra1 = 6'd0;
        #1;
        chk("r0_rsv_ready", {31'd0, bus.rsv_ready}, 32'd1);
        step();
        bus.rsv_valid = 1'b0;
        chk("r0_haz1", {31'd0, bus.haz1}, 32'd0);
        chk("r0_rsv_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
    endtask

    task automatic test_err();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 6'd9; bus.wb0_data = 32'h55;
        step();
        bus.wb0_valid = 1'b0;
        chk("err_rf_we", {31'd0, bus.rf_we}, 32'd1);
        chk("err_rf_wa", {26'd0, bus.rf_wa}, 32'd9);
        chk("err_rf_wd", bus.rf_wd, 32'h55);
        chk("err_set", {31'd0, bus.wb_err}, 32'd1);
        chk("err_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", {31'd0, bus.wb_err}, 32'd1);
    endtask

    task automatic test_async_reset();
        reserve(6'd7);
        reserve(6'd8);
        bus.q_ra1 = 6'd7;
        #1;
        chk("ar_haz1_pre", {31'd0, bus.haz1}, 32'd1);
        chk("ar_busy_cnt_pre", {25'd0, bus.busy_cnt}, 32'd2);
        bus.wb0_valid = 1'b1; bus.wb0_addr = 6'd8; bus.wb0_data = 32'hCAFE;
        step();
        bus.wb0_valid = 1'b0;
        chk("ar_rf_we_inflight", {31'd0, bus.rf_we}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("ar_busy_cnt", {25'd0, bus.busy_cnt}, 32'd0);
        chk("ar_haz1", {31'd0, bus.haz1}, 32'd0);
        chk("ar_wb_err", {31'd0, bus.wb_err}, 32'd0);
        #1;
        reset = 1'b0;
        step();
        bus.wb0_valid = 1'b1; bus.wb0_addr = 6'd0; bus.wb0_data = 32'h1;
        bus.wb1_valid = 1'b1; bus.wb1_addr = 6'd0; bus.wb1_data = 32'h2;
        #1;
        chk("ar_post_wb0_ready", {31'd0, bus.wb0_ready}, 32'd1);
        chk("ar_post_wb1_ready", {31'd0, bus.wb1_ready}, 32'd0);
        step();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_reserve();
        test_writeback();
        test_arbitration();
        test_reg0();
        test_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
